// File: rtl/tt_sel_seq_pkg.sv
// rtl/tt_sel_seq_pkg.sv - default widths and helpers for the design-select sequencer
package tt_sel_seq_pkg;

  localparam int TT_SEL_ADDR_W   = 10;
  localparam int TT_SEL_RST_W    = 4;
  localparam int TT_SEL_SETTLE_W = 2;
  localparam int TT_SEL_PULSE_W  = 2;

  // One timer width covers every phase so a single counter type serves all of them.
  function automatic int sel_timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tt_sel_timer.sv
// rtl/tt_sel_timer.sv - loadable phase down-counter with zero flag
module tt_sel_timer #(
  parameter int W    = 3,
  parameter int LOAD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  logic [W-1:0] cnt;

  // Loads N-1 on phase entry so the phase lasts exactly N cycles ending at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOAD - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// rtl/tt_sel_seq.sv - design-select sequencer driving sel_rst_n / sel_inc / ena
module tt_sel_seq
  import tt_sel_seq_pkg::*;
#(
  parameter int ADDR_W   = TT_SEL_ADDR_W,
  parameter int RST_W    = TT_SEL_RST_W,
  parameter int SETTLE_W = TT_SEL_SETTLE_W,
  parameter int PULSE_W  = TT_SEL_PULSE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              sel_rst_n,
  output logic              sel_inc,
  output logic              ena,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid
);

  localparam int TW = sel_timer_w(RST_W, SETTLE_W, PULSE_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SETTLE,
    S_INC_HI,
    S_INC_LO,
    S_ENA
  } state_t;

  state_t state, state_next;
  logic [ADDR_W-1:0] inc_cnt;
  logic rst_zero, settle_zero, pulse_zero;
  logic accept;
  logic sel_rst_n_d, sel_inc_d, ena_d, busy_d, done_d, req_ready_d, cur_valid_d;

  assign accept = req_valid & req_ready;

  tt_sel_timer #(.W(TW), .LOAD(RST_W)) u_rst_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state_next == S_RST && state != S_RST),
    .zero (rst_zero)
  );

  tt_sel_timer #(.W(TW), .LOAD(SETTLE_W)) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state_next == S_SETTLE && state != S_SETTLE),
    .zero (settle_zero)
  );

  tt_sel_timer #(.W(TW), .LOAD(PULSE_W)) u_pulse_timer (
    .clk  (clk),
    .rst  (rst),
    .load ((state_next == S_INC_HI || state_next == S_INC_LO) && state_next != state),
    .zero (pulse_zero)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_RST;
      S_RST:    if (rst_zero) state_next = S_SETTLE;
      S_SETTLE: if (settle_zero) state_next = (inc_cnt == '0) ? S_ENA : S_INC_HI;
      S_INC_HI: if (pulse_zero) state_next = S_INC_LO;
      // inc_cnt is decremented on this same edge, so ==1 means the last pulse just ended.
      S_INC_LO: if (pulse_zero) state_next = (inc_cnt == ADDR_W'(1)) ? S_ENA : S_INC_HI;
      S_ENA:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state and registered, so they align with state.
  always_comb begin
    sel_rst_n_d = 1'b1;
    sel_inc_d   = 1'b0;
    ena_d       = ena;
    cur_valid_d = cur_valid;
    done_d      = 1'b0;
    busy_d      = 1'b1;
    req_ready_d = 1'b0;
    case (state_next)
      S_IDLE: begin
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
      end
      S_RST: begin
        sel_rst_n_d = 1'b0;
        ena_d       = 1'b0;
        cur_valid_d = 1'b0;
      end
      S_INC_HI: sel_inc_d = 1'b1;
      S_ENA: begin
        ena_d       = 1'b1;
        cur_valid_d = 1'b1;
        done_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      inc_cnt   <= '0;
      cur_addr  <= '0;
      sel_rst_n <= 1'b0;
      sel_inc   <= 1'b0;
      ena       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
      cur_valid <= 1'b0;
    end else begin
      state     <= state_next;
      sel_rst_n <= sel_rst_n_d;
      sel_inc   <= sel_inc_d;
      ena       <= ena_d;
      busy      <= busy_d;
      done      <= done_d;
      req_ready <= req_ready_d;
      cur_valid <= cur_valid_d;
      if (accept) begin
        inc_cnt  <= req_addr;
        cur_addr <= req_addr;
      end else if (state == S_INC_LO && pulse_zero) begin
        inc_cnt <= inc_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
// tb/tb_tt_sel_seq.sv - self-checking bench for tt_sel_seq
module tb_tt_sel_seq;

  localparam int AW = 10;
  localparam int RW = 4;
  localparam int SW = 2;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic req_ready, sel_rst_n, sel_inc, ena, busy, done, cur_valid;
  logic [AW-1:0] cur_addr;

  always #5 clk = ~clk;

  tt_sel_seq #(.ADDR_W(AW), .RST_W(RW), .SETTLE_W(SW), .PULSE_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .sel_rst_n (sel_rst_n),
    .sel_inc   (sel_inc),
    .ena       (ena),
    .busy      (busy),
    .done      (done),
    .cur_addr  (cur_addr),
    .cur_valid (cur_valid)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: expected pins follow from accept time and address by plain arithmetic.
  int cyc = 0;
  bit m_rstp = 1'b1;
  bit pending = 1'b0;
  bit m_ena = 1'b0;
  int acc_cyc = 0, acc_addr = 0, m_cur = 0;
  int acc_count = 0, done_count = 0;
  int last_done_cyc = 0, last_done_pulses = 0, last_done_addr = 0;
  int pulse_cnt = 0;
  logic prev_inc = 1'b0;

  always @(negedge clk) begin : mon
    int rel, o, e_cur;
    bit e_busy, e_ready, e_rstn, e_inc, e_done, e_ena;
    logic [16:0] ev, av;
    cyc++;
    if (m_rstp) begin
      e_busy = 0; e_ready = 0; e_rstn = 0; e_inc = 0; e_done = 0; e_ena = 0; e_cur = 0;
    end else begin
      rel     = cyc - acc_cyc;
      e_busy  = pending && rel > 0;
      e_ready = !e_busy;
      e_rstn  = !(e_busy && rel <= RW);
      o       = rel - 1 - RW - SW;
      e_inc   = e_busy && o >= 0 && o < 2 * PW * acc_addr && (o % (2 * PW)) < PW;
      e_done  = e_busy && rel == 1 + RW + SW + 2 * PW * acc_addr;
      e_ena   = e_done ? 1'b1 : (e_busy ? 1'b0 : m_ena);
      e_cur   = e_busy ? acc_addr : m_cur;
    end
    ev = {e_ready, e_rstn, e_inc, e_ena, e_busy, e_done, e_ena, AW'(e_cur)};
    av = {req_ready, sel_rst_n, sel_inc, ena, busy, done, cur_valid, cur_addr};
    chk(av === ev, "outputs{rdy,rstn,inc,ena,busy,done,cv,addr}", av, ev);
    chk(!(sel_inc && !sel_rst_n) && !(done && !ena) && !(ena && busy && !done),
        "invariant{inc,rstn,done,ena,busy}", {sel_inc, sel_rst_n, done, ena, busy}, 0);

    if (sel_rst_n !== 1'b1) pulse_cnt = 0;
    else if (sel_inc === 1'b1 && prev_inc !== 1'b1) pulse_cnt++;
    prev_inc = sel_inc;
    if (done === 1'b1) begin
      chk(pulse_cnt == int'(cur_addr), "pulses_at_ena", pulse_cnt, cur_addr);
      done_count++;
      last_done_cyc    = cyc;
      last_done_pulses = pulse_cnt;
      last_done_addr   = int'(cur_addr);
    end

    m_ena = e_ena;
    m_cur = e_cur;
    if (e_done) pending = 0;
    if (req_valid && e_ready && !rst) begin
      pending   = 1;
      acc_cyc   = cyc;
      acc_addr  = int'(req_addr);
      acc_count++;
    end
    if (rst) begin
      pending = 0;
      m_ena   = 0;
      m_cur   = 0;
      m_rstp  = 1;
    end else begin
      m_rstp = 0;
    end
  end

  task automatic wait_accept(input int c0);
    bit ok;
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk); #1;
      if (acc_count != c0) ok = 1;
    end
    chk(ok, "accept_timeout", ok, 1);
  endtask

  task automatic send(input int a);
    int c0;
    c0 = acc_count;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = AW'(a);
    wait_accept(c0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
  endtask

  task automatic wait_done(output int lat, output int pulses);
    int c0;
    bit ok;
    c0 = done_count;
    ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk); #1;
      if (done_count != c0) ok = 1;
    end
    chk(ok, "done_timeout", ok, 1);
    lat    = last_done_cyc - acc_cyc;
    pulses = last_done_pulses;
  endtask

  typedef struct {
    int addr;
    int exp_lat;
    int exp_pulses;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, pulses, d1, c0, dc0;
    bit ok;
    vecs[0] = '{3, 19, 3};
    vecs[1] = '{0, 7, 0};
    vecs[2] = '{1, 11, 1};
    vecs[3] = '{1023, 4099, 1023};
    vecs[4] = '{7, 35, 7};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].addr);
      wait_done(lat, pulses);
      chk(lat == vecs[i].exp_lat, $sformatf("latency[addr=%0d]", vecs[i].addr), lat, vecs[i].exp_lat);
      chk(pulses == vecs[i].exp_pulses, $sformatf("pulses[addr=%0d]", vecs[i].addr), pulses, vecs[i].exp_pulses);
      repeat (2) @(posedge clk);
    end

    // req_valid held through busy, address changed mid-sequence, back-to-back accept
    c0 = acc_count;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = AW'(3);
    wait_accept(c0);
    c0 = acc_count;
    repeat (8) @(posedge clk);
    #1 req_addr = AW'(5);
    wait_done(lat, pulses);
    d1 = last_done_cyc;
    chk(last_done_addr == 3, "held_first_addr", last_done_addr, 3);
    chk(pulses == 3, "held_first_pulses", pulses, 3);
    wait_accept(c0);
    chk(acc_cyc == d1 + 1, "back_to_back_accept", acc_cyc - d1, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(lat, pulses);
    chk(pulses == 5, "held_second_pulses", pulses, 5);
    chk(lat == 27, "held_second_latency", lat, 27);

    // rst during the second INC_HI abandons the pulse train
    repeat (2) @(posedge clk);
    send(3);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (pulse_cnt == 2) ok = 1;
    end
    chk(ok, "reach_second_pulse", ok, 1);
    dc0 = done_count;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk(done_count == dc0, "no_done_after_rst", done_count - dc0, 0);
    send(2);
    wait_done(lat, pulses);
    chk(lat == 15, "post_rst_latency", lat, 15);
    chk(pulses == 2, "post_rst_pulses", pulses, 2);

    // randomized requests with random gaps; checked cycle by cycle by the model
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(int'($urandom_range(0, 20)));
      wait_done(lat, pulses);
      chk(pulses == acc_addr, "rand_pulses", pulses, acc_addr);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
